// File: rtl/slice_pkg.sv
// -----------------------------------------------------------------------------
// slice_pkg
// Shared types and helpers for the slice concatenating serializer.
//   state_t   : serializer FSM state (IDLE, LOAD, STREAM)
//   CH_OUT    : output channel count for the default configuration
//   N_ELEM    : frame length for the default configuration
//   ch_out()  : output channel count for a given LAYER_num
//   n_elem()  : frame length in beats for a given LAYER_num and side W
//   cnt_width : counter width able to hold 0..n-1 (at least 1 bit)
//   elem_idx  : flat element index ((l*W + r)*W + c)
// -----------------------------------------------------------------------------
package slice_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam int LAYER_NUM_DEF  = 1;
    localparam int WIDTH_OUT_DEF  = 80;
    localparam int WIDTH_EACH_DEF = 16;

    localparam int CH_OUT = 4 * LAYER_NUM_DEF;
    localparam int N_ELEM = CH_OUT * WIDTH_OUT_DEF * WIDTH_OUT_DEF;

    function automatic int ch_out(input int layer_num);
        return 4 * layer_num;
    endfunction

    function automatic int n_elem(input int layer_num, input int w);
        return ch_out(layer_num) * w * w;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int elem_idx(input int l, input int r, input int c, input int w);
        return (l * w + r) * w + c;
    endfunction

endpackage

// File: rtl/slice_concat_ctr.sv
// -----------------------------------------------------------------------------
// slice_concat_ctr
// Cascaded column / row / channel counters for the serializer. The counters
// always point at the element currently presented on the output; the nxt_*
// outputs give the element that follows it, so the data register can be
// loaded on the same edge that advances the counters.
//   clk, rst       : clock, asynchronous active-high reset
//   clr            : return all counters to zero (frame capture)
//   adv            : advance by one element (beat accepted)
//   c, r, k        : current column, row and output channel
//   nxt_c/r/k      : successor of the current position (with wrap)
//   term           : current position is the final element of the frame
// -----------------------------------------------------------------------------
module slice_concat_ctr
    import slice_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 2,
    parameter int CW = 1,
    parameter int KW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] c,
    output logic [CW-1:0] r,
    output logic [KW-1:0] k,
    output logic [CW-1:0] nxt_c,
    output logic [CW-1:0] nxt_r,
    output logic [KW-1:0] nxt_k,
    output logic          term
);

    localparam logic [CW-1:0] W_MAX = CW'(W - 1);
    localparam logic [KW-1:0] K_MAX = KW'(CH - 1);

    logic c_wrap;
    logic r_wrap;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the untaken paths infer latches.
    always_comb begin
        c_wrap = (c == W_MAX);
        r_wrap = (r == W_MAX);
        nxt_c  = c_wrap ? '0 : c + 1'b1;
        nxt_r  = r;
        nxt_k  = k;
        if (c_wrap) begin
            nxt_r = r_wrap ? '0 : r + 1'b1;
            if (r_wrap) begin
                nxt_k = (k == K_MAX) ? '0 : k + 1'b1;
            end
        end
        term = c_wrap && r_wrap && (k == K_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= '0;
            r <= '0;
            k <= '0;
        end else if (clr) begin
            c <= '0;
            r <= '0;
            k <= '0;
        end else if (adv) begin
            c <= nxt_c;
            r <= nxt_r;
            k <= nxt_k;
        end
    end

endmodule

// File: rtl/slice_concat_ser.sv
// -----------------------------------------------------------------------------
// slice_concat_ser
// Captures the four space-to-depth sub-image buses in one handshake and
// streams them as a valid/ready pixel stream, channel-concatenated in slice
// order 1..4, each channel in raster order. Holds one frame only.
//   clk, rst              : clock, asynchronous active-high reset
//   slice_in_1..4         : flat sub-image buses, element (l,r,c) at
//                           bits [((l*W+r)*W+c)*WE +: WE]
//   in_valid / in_ready   : frame capture handshake (in_ready registered)
//   out_data / out_valid  : current element and its valid
//   out_ready             : downstream accepts the beat
//   out_last              : final element of the frame
//   out_chan              : output channel k = slice*LAYER_num + layer
//   busy                  : a frame is held or streaming
//   out_eol               : element is at the last column of its row
//                           (only when SLICE_CONCAT_EOL_EN is defined)
// -----------------------------------------------------------------------------
module slice_concat_ser
    import slice_pkg::*;
#(
    parameter int  LAYER_num       = LAYER_NUM_DEF,
    parameter int  WIDTH_out_data  = WIDTH_OUT_DEF,
    parameter int  WIDTH_each_data = WIDTH_EACH_DEF,
    localparam int KW    = cnt_width(ch_out(LAYER_num)),
    localparam int BUS_W = LAYER_num * WIDTH_out_data * WIDTH_out_data * WIDTH_each_data
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BUS_W-1:0]           slice_in_1,
    input  logic [BUS_W-1:0]           slice_in_2,
    input  logic [BUS_W-1:0]           slice_in_3,
    input  logic [BUS_W-1:0]           slice_in_4,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH_each_data-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [KW-1:0]              out_chan,
    output logic                       busy
`ifdef SLICE_CONCAT_EOL_EN
    ,
    output logic                       out_eol
`endif
);

    localparam int W          = WIDTH_out_data;
    localparam int WE         = WIDTH_each_data;
    localparam int CH_N       = ch_out(LAYER_num);
    localparam int SLICE_ELEM = LAYER_num * W * W;
    localparam int FRAME_N    = n_elem(LAYER_num, W);
    localparam int CW         = cnt_width(W);
    localparam int IW         = cnt_width(FRAME_N);

    state_t          state;
    state_t          next_state;
    logic            capture;
    logic            load_first;
    logic            advance;
    logic [CW-1:0]   c;
    logic [CW-1:0]   r;
    logic [KW-1:0]   k;
    logic [CW-1:0]   nxt_c;
    logic [CW-1:0]   nxt_r;
    logic [KW-1:0]   nxt_k;
    logic            term;
    logic [IW-1:0]   rd_idx;
    logic [WE-1:0]   store [FRAME_N];

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && in_ready) next_state = LOAD;
            LOAD:    next_state = STREAM;
            STREAM:  if (out_valid && out_ready && term) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Control outputs of the FSM.
    always_comb begin
        capture    = 1'b0;
        load_first = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE:    capture    = in_valid && in_ready;
            LOAD:    load_first = 1'b1;
            STREAM:  advance    = out_valid && out_ready;
            default: ;
        endcase
    end

    slice_concat_ctr #(
        .CH (CH_N),
        .W  (W),
        .CW (CW),
        .KW (KW)
    ) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (capture),
        .adv   (advance),
        .c     (c),
        .r     (r),
        .k     (k),
        .nxt_c (nxt_c),
        .nxt_r (nxt_r),
        .nxt_k (nxt_k),
        .term  (term)
    );

    // Slice s occupies store[s*SLICE_ELEM +: SLICE_ELEM], so channel k maps
    // straight onto elem_idx(k, r, c) without splitting k into slice/layer.
    // NOTE: the frame store is plain storage with no reset; it is always
    // rewritten by a capture before any element of it is presented.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int e = 0; e < SLICE_ELEM; e++) begin
                store[e]                  <= slice_in_1[e*WE +: WE];
                store[SLICE_ELEM + e]     <= slice_in_2[e*WE +: WE];
                store[2 * SLICE_ELEM + e] <= slice_in_3[e*WE +: WE];
                store[3 * SLICE_ELEM + e] <= slice_in_4[e*WE +: WE];
            end
        end
    end

    // LOAD presents the element at the (cleared) counters; STREAM presents
    // the successor on the edge that accepts the current beat.
    always_comb begin
        if (load_first) begin
            rd_idx = IW'(elem_idx(int'(k), int'(r), int'(c), W));
        end else begin
            rd_idx = IW'(elem_idx(int'(nxt_k), int'(nxt_r), int'(nxt_c), W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == STREAM);
            if (load_first || (advance && !term)) begin
                out_data <= store[rd_idx];
            end
        end
    end

    // Position flags decode the registered counters, so they stay aligned
    // with out_data and hold under backpressure.
    assign out_last = out_valid && term;
    assign out_chan = k;
    assign busy     = (state != IDLE);

`ifdef SLICE_CONCAT_EOL_EN
    localparam logic [CW-1:0] W_MAX = CW'(W - 1);
    assign out_eol = out_valid && (c == W_MAX);
`endif

endmodule

// File: tb/tb_slice_concat_ser.sv
module tb_slice_concat_ser;

    localparam int W    = 2;
    localparam int WE   = 16;
    localparam int L1   = 1;
    localparam int L2   = 2;
    localparam int BUS1 = L1 * W * W * WE;
    localparam int BUS2 = L2 * W * W * WE;
    localparam int N1   = 4 * L1 * W * W;
    localparam int N2   = 4 * L2 * W * W;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  chan;
        logic        last;
        logic        eol;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance a: LAYER_num=1
    logic [BUS1-1:0] a_s [4];
    logic            a_in_valid = 1'b0;
    logic            a_in_ready;
    logic [WE-1:0]   a_out_data;
    logic            a_out_valid;
    logic            a_out_ready = 1'b0;
    logic            a_out_last;
    logic [1:0]      a_out_chan;
    logic            a_busy;

    // Instance b: LAYER_num=2
    logic [BUS2-1:0] b_s [4];
    logic            b_in_valid = 1'b0;
    logic            b_in_ready;
    logic [WE-1:0]   b_out_data;
    logic            b_out_valid;
    logic            b_out_ready = 1'b0;
    logic            b_out_last;
    logic [2:0]      b_out_chan;
    logic            b_busy;

`ifdef SLICE_CONCAT_EOL_EN
    logic a_out_eol;
    logic b_out_eol;
`endif

    always #5 clk = ~clk;

    slice_concat_ser #(.LAYER_num(L1), .WIDTH_out_data(W), .WIDTH_each_data(WE)) dut (
        .clk(clk), .rst(rst),
        .slice_in_1(a_s[0]), .slice_in_2(a_s[1]), .slice_in_3(a_s[2]), .slice_in_4(a_s[3]),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last), .out_chan(a_out_chan), .busy(a_busy)
`ifdef SLICE_CONCAT_EOL_EN
        , .out_eol(a_out_eol)
`endif
    );

    slice_concat_ser #(.LAYER_num(L2), .WIDTH_out_data(W), .WIDTH_each_data(WE)) dut2 (
        .clk(clk), .rst(rst),
        .slice_in_1(b_s[0]), .slice_in_2(b_s[1]), .slice_in_3(b_s[2]), .slice_in_4(b_s[3]),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .out_chan(b_out_chan), .busy(b_busy)
`ifdef SLICE_CONCAT_EOL_EN
        , .out_eol(b_out_eol)
`endif
    );

    // Element i of slice s carries tag | s<<8 | i.
    task automatic fill(input int sel, input logic [15:0] tag);
        int nl;
        logic [15:0] v;
        nl = sel ? L2 : L1;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < nl * W * W; i++) begin
                v = tag | 16'(s << 8) | 16'(i);
                if (sel != 0) b_s[s][i*WE +: WE] = v;
                else          a_s[s][i*WE +: WE] = v;
            end
        end
    endtask

    // Expected order: slice, layer, row, column.
    task automatic push_expected(input int sel, input logic [15:0] tag);
        int nl;
        int idx;
        beat_t b;
        nl = sel ? L2 : L1;
        for (int s = 0; s < 4; s++)
            for (int l = 0; l < nl; l++)
                for (int r = 0; r < W; r++)
                    for (int c = 0; c < W; c++) begin
                        idx    = (l * W + r) * W + c;
                        b.data = tag | 16'(s << 8) | 16'(idx);
                        b.chan = 3'(s * nl + l);
                        b.last = (s == 3) && (l == nl - 1) && (r == W - 1) && (c == W - 1);
                        b.eol  = (c == W - 1);
                        sb.push_back(b);
                    end
    endtask

    task automatic start_frame(input int sel, input logic [15:0] tag);
        int t;
        logic rdy;
        fill(sel, tag);
        t   = 0;
        rdy = sel ? b_in_ready : a_in_ready;
        while (!rdy && t < 50) begin
            @(negedge clk);
            t++;
            rdy = sel ? b_in_ready : a_in_ready;
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL in_ready_wait: in_ready=%b required 1 within 50 cycles", rdy);
        end
        if (sel != 0) b_in_valid = 1'b1; else a_in_valid = 1'b1;
        push_expected(sel, tag);
        @(negedge clk);
        b_in_valid = 1'b0;
        a_in_valid = 1'b0;
        // One cycle after capture: LOAD, nothing presented yet.
        checks++;
        if (sel != 0) begin
            if (b_out_valid !== 1'b0 || b_busy !== 1'b1 || b_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_cycle: valid=%b busy=%b in_ready=%b required 0 1 0", b_out_valid, b_busy, b_in_ready);
            end
        end else begin
            if (a_out_valid !== 1'b0 || a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL load_cycle: valid=%b busy=%b in_ready=%b required 0 1 0", a_out_valid, a_busy, a_in_ready);
            end
        end
    endtask

    // mode 0: out_ready=1; mode 1: out_ready pattern 1,0,0,1.
    // inject_at >= 0: pulse in_valid with new bus data at that beat.
    // stop_after >= 0: return after that many beats, leaving the rest queued.
    task automatic collect(input int sel, input int mode, input int inject_at,
                           input int stop_after, input string name);
        int acc, cyc, first, last_acc, n_exp;
        logic stalled, injected, rdy, ov, ol, oe, irdy, obusy;
        logic [15:0] od, hd;
        logic [2:0] oc, hc;
        logic hl;
        beat_t e;
        acc = 0; cyc = 0; first = -1; last_acc = -1; n_exp = sb.size();
        stalled = 1'b0; injected = 1'b0; hd = '0; hc = '0; hl = 1'b0;
        while (sb.size() != 0 && cyc < 400) begin
            if (stop_after >= 0 && acc >= stop_after) break;
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (sel != 0) b_out_ready = rdy; else a_out_ready = rdy;
            if (inject_at >= 0 && acc == inject_at && !injected) begin
                fill(sel, 16'h8000);
                if (sel != 0) b_in_valid = 1'b1; else a_in_valid = 1'b1;
                injected = 1'b1;
            end else begin
                a_in_valid = 1'b0;
                b_in_valid = 1'b0;
            end
            ov = sel ? b_out_valid : a_out_valid;
            od = sel ? b_out_data  : a_out_data;
            oc = sel ? b_out_chan  : {1'b0, a_out_chan};
            ol = sel ? b_out_last  : a_out_last;
`ifdef SLICE_CONCAT_EOL_EN
            oe = sel ? b_out_eol : a_out_eol;
`else
            oe = 1'b0;
`endif
            if (stalled) begin
                checks++;
                if (od !== hd || oc !== hc || ol !== hl) begin
                    failures++;
                    $display("FAIL %s stall_hold: data=%h chan=%0d last=%b required %h %0d %b", name, od, oc, ol, hd, hc, hl);
                end
            end
            if (ov === 1'b1 && first < 0) first = cyc;
            if (ov === 1'b1 && rdy) begin
                e = sb.pop_front();
                checks++;
                if (od !== e.data || oc !== e.chan || ol !== e.last) begin
                    failures++;
                    $display("FAIL %s beat %0d: data=%h chan=%0d last=%b required %h %0d %b", name, acc, od, oc, ol, e.data, e.chan, e.last);
                end
`ifdef SLICE_CONCAT_EOL_EN
                checks++;
                if (oe !== e.eol) begin
                    failures++;
                    $display("FAIL %s eol beat %0d: eol=%b required %b", name, acc, oe, e.eol);
                end
`endif
                acc++;
                last_acc = cyc;
                stalled  = 1'b0;
            end else if (ov === 1'b1) begin
                stalled = 1'b1;
                hd = od; hc = oc; hl = ol;
            end else begin
                stalled = 1'b0;
                if (oe !== 1'b0 || ol !== 1'b0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s idle_flags: last=%b eol=%b required 0 0", name, ol, oe);
                end
            end
            @(negedge clk);
            cyc++;
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        if (stop_after < 0) begin
            checks++;
            if (sb.size() != 0) begin
                failures++;
                $display("FAIL %s timeout: beats accepted=%0d required %0d", name, acc, n_exp);
                sb.delete();
            end
            // One cycle after the last acceptance: idle and ready again.
            irdy  = sel ? b_in_ready : a_in_ready;
            ov    = sel ? b_out_valid : a_out_valid;
            obusy = sel ? b_busy : a_busy;
            checks++;
            if (irdy !== 1'b1 || ov !== 1'b0 || obusy !== 1'b0) begin
                failures++;
                $display("FAIL %s frame_end: in_ready=%b out_valid=%b busy=%b required 1 0 0", name, irdy, ov, obusy);
            end
            if (mode == 0) begin
                checks++;
                if (last_acc - first + 1 != n_exp) begin
                    failures++;
                    $display("FAIL %s throughput: span=%0d cycles required %0d", name, last_acc - first + 1, n_exp);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_in_ready, a_out_valid, a_out_last, a_busy, b_in_ready, b_out_valid, b_busy} !== 7'b0
            || a_out_data !== 16'h0 || a_out_chan !== 2'd0 || b_out_chan !== 3'd0) begin
            failures++;
            $display("FAIL reset_values: in_ready=%b valid=%b last=%b busy=%b data=%h chan=%0d required all 0",
                     a_in_ready, a_out_valid, a_out_last, a_busy, a_out_data, a_out_chan);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b/%b required 1/1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_ordering;
        start_frame(0, 16'h0000);
        collect(0, 0, -1, -1, "ordering");
    endtask

    task automatic test_backpressure;
        start_frame(0, 16'h1000);
        collect(0, 1, -1, -1, "backpressure");
    endtask

    task automatic test_ignored_input;
        start_frame(0, 16'h2000);
        collect(0, 0, 7, -1, "ignored_input");
        start_frame(0, 16'h4000);
        collect(0, 0, -1, -1, "next_frame");
    endtask

    task automatic test_multi_layer;
        start_frame(1, 16'h0000);
        collect(1, 0, -1, -1, "multi_layer");
        start_frame(1, 16'h5000);
        collect(1, 1, -1, -1, "multi_layer_bp");
    endtask

`ifdef SLICE_CONCAT_EOL_EN
    task automatic test_eol;
        start_frame(0, 16'h6000);
        collect(0, 1, -1, -1, "eol");
    endtask
`endif

    task automatic test_reset_midframe;
        start_frame(0, 16'h7000);
        collect(0, 0, -1, 5, "reset_mid");
        rst = 1'b1;
        #1;
        checks++;
        if ({a_in_ready, a_out_valid, a_out_last, a_busy} !== 4'b0 || a_out_data !== 16'h0 || a_out_chan !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: in_ready=%b valid=%b last=%b busy=%b data=%h chan=%0d required all 0",
                     a_in_ready, a_out_valid, a_out_last, a_busy, a_out_data, a_out_chan);
        end
`ifdef SLICE_CONCAT_EOL_EN
        checks++;
        if (a_out_eol !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_eol: eol=%b required 0", a_out_eol);
        end
`endif
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release: in_ready=%b required 0 before first edge", a_in_ready);
        end
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_rise: in_ready=%b required 1 one edge after release", a_in_ready);
        end
        start_frame(0, 16'h3000);
        collect(0, 0, -1, -1, "after_reset");
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            a_s[s] = '0;
            b_s[s] = '0;
        end
        test_reset();
        test_ordering();
        test_backpressure();
        test_ignored_input();
        test_multi_layer();
`ifdef SLICE_CONCAT_EOL_EN
        test_eol();
`endif
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
